ctrl_pipeline: RTL and testbench
================================

// Module: ctrl_pipeline
// PURPOSE
//  Pipelined successor of the combinational opcode decoder. Decodes the ID-stage opcode through sub-module
//  ctrl_decode, then carries the control bundle down EX/MEM/WB, gating every stage output with its valid bit.
//  Adds RAW-hazard stall, a compare flag register, taken-branch flush and optional operand-forwarding selects.
// PARAMETERS
//  OPCODE_W    4  opcode width (>=4); decode uses opcode[3:0], upper bits must be 0, else decoded as NOP
//  REG_ADDR_W  4  register-address width
//  ALU_CTRL_W  3  ALU control width
// PORTS
//  clk              in   1           clock
//  rst              in   1           synchronous, active-high reset
//  id_valid         in   1           ID holds an instruction
//  id_ready         out  1           instruction accepted this cycle (= ~stall | flush)
//  id_opcode        in   OPCODE_W    ID opcode
//  id_rs_a/id_rs_b  in   REG_ADDR_W  source registers
//  id_rd            in   REG_ADDR_W  destination register
//  ex_cmp_result    in   1           ALU compare outcome for the instruction in EX
//  ex_valid         out  1           EX stage valid
//  ex_sel_b         out  2           0 ALU, 1 load offset, 2 store offset
//  ex_alu_ctrl      out  ALU_CTRL_W  ALU operation
//  mem_we/mem_re    out  1           memory write / read enable (MEM stage)
//  wb_reg_we        out  1           register write enable (WB stage)
//  wb_sel_data_out  out  2           0 ALU, 1 immediate, 2 load
//  wb_rd            out  REG_ADDR_W  write-back register
//  stall            out  1           RAW hazard is holding ID
//  branch_taken     out  1           BT in EX with flag set
//  flush            out  1           ID instruction discarded this cycle
// BEHAVIOUR
//  - Reset: all stage valids, enables, selects, wb_rd and the flag are 0. id_ready=1 the cycle after reset.
//  - Opcodes (ctrl_pkg): 0xxx ALU ops, 0110 NOT, 1000 CMP, 1011 MOV, 1100 LD, 1101 ST, 1110 BT, 1111 NOP.
//    Enables, selects and RE_A/RE_B follow this opcode table.
//  - alu_ctrl: opcode[2:0] for 0xxx. ALU_SUB for CMP. ALU_ADD otherwise.
//  - Advance: stages shift every cycle, no downstream backpressure. ID enters EX on id_valid & id_ready &
//    ~flush. Otherwise EX takes a bubble with every field 0. A stage output is 0 whenever its valid is 0.
//  - Latency: an instruction accepted at edge N is in EX after N, MEM after N+1, WB after N+2.
//  - Hazard: a producer is an EX or MEM stage that is valid with reg_we set and rd equal to a read source
//    (RE_A->rs_a, RE_B->rs_b). The register file is write-through, so WB is never a hazard.
//    Register 0 is not special.
//  - Flag: updates to ex_cmp_result at the end of a cycle in which EX holds a valid CMP. Holds otherwise.
//    CMP immediately followed by BT sees the new flag.
//  - branch_taken = ex_valid & EX is BT & flag. flush = branch_taken.
//    On flush, the ID instruction is consumed (id_ready=1) and dropped. Flush overrides stall.
//  - BT with flag=0 falls through: no flush, no register write.
//  - id_valid=0 has no hazard effect. stall=0 when id_valid=0.
//  - Reset mid-operation clears all in-flight state on that edge, including a pending stall.
// CONFIGURATION
//  CTRL_FORWARD_EN not defined:
//    - stall on any hazard; dependent back-to-back ALU ops stall 2 cycles.
//  CTRL_FORWARD_EN defined:
//    - adds ex_fwd_a/ex_fwd_b out 2, registered with the bundle: 00 regfile, 01 MEM result, 10 WB result.
//    - the nearest producer wins.
//    - stall only when the EX producer is LD (load-use, 1 cycle). After the stall, fwd selects 10.
// STRUCTURE
//  - ctrl_pkg: opcode localparams, ALU_ADD/ALU_SUB, SEL_B_* and SEL_OUT_* encodings, ctrl_bundle_t
//    (sel_b, alu_ctrl, mem_we, mem_re, reg_we, sel_data_out, re_a, re_b, cmp_en, branch, is_load).
//  - ctrl_decode: combinational opcode -> ctrl_bundle_t.
//  - ctrl_pipeline: stage registers, hazard compare, flag, flush.
// TESTING
//  1 reset; ADD op 0001 rd=3 -> ex_valid, ex_alu_ctrl=001 next cycle; wb_reg_we=1, wb_rd=3 two cycles later.
//  2 ADD rd=2 then SUB rs_a=2 back-to-back -> no fwd: stall=1 for 2 cycles;
//    fwd: 0 stalls and SUB has ex_fwd_a=01.
//  3 LD rd=5 then ADD rs_b=5 -> fwd: 1 stall cycle, then ex_fwd_b=10, sel_b=0; no fwd: 2 stall cycles.
//  4 CMP with ex_cmp_result=1, then BT, then ADD rd=7 -> branch_taken=flush=1 in BT's EX cycle;
//    ADD never reaches ex_valid; no wb_reg_we for rd 7.
//  5 CMP with ex_cmp_result=0, then BT -> branch_taken=0; the next instruction proceeds normally.
//  6 rst pulse while stall=1 and all stages valid -> next cycle all valids 0, flag 0, id_ready=1, wb_reg_we=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared opcode, ALU, select and forwarding encodings plus the control bundle
// produced by ctrl_decode and consumed by ctrl_pipeline.
package ctrl_pkg;

    localparam logic [3:0] OP_NOT = 4'b0110;
    localparam logic [3:0] OP_CMP = 4'b1000;
    localparam logic [3:0] OP_MOV = 4'b1011;
    localparam logic [3:0] OP_LD  = 4'b1100;
    localparam logic [3:0] OP_ST  = 4'b1101;
    localparam logic [3:0] OP_BT  = 4'b1110;
    localparam logic [3:0] OP_NOP = 4'b1111;

    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_MEM     = 2'b01;
    localparam logic [1:0] FWD_WB      = 2'b10;

    typedef enum logic [1:0] {
        SEL_B_ALU   = 2'd0,
        SEL_B_LOAD  = 2'd1,
        SEL_B_STORE = 2'd2
    } sel_b_t;

    typedef enum logic [1:0] {
        SEL_OUT_ALU  = 2'd0,
        SEL_OUT_IMM  = 2'd1,
        SEL_OUT_LOAD = 2'd2
    } sel_out_t;

    typedef struct packed {
        sel_b_t     sel_b;
        logic [2:0] alu_ctrl;
        logic       mem_we;
        logic       mem_re;
        logic       reg_we;
        sel_out_t   sel_data_out;
        logic       re_a;
        logic       re_b;
        logic       cmp_en;
        logic       branch;
        logic       is_load;
    } ctrl_bundle_t;

    // The producer one stage ahead holds the youngest value, so it wins over the older one.
    function automatic logic [1:0] fwdSelect(input logic nearHit, input logic farHit);
        if (nearHit)
            return FWD_MEM;
        else if (farHit)
            return FWD_WB;
        else
            return FWD_REGFILE;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: maps the ID opcode to a ctrl_bundle_t.
// Opcodes with any bit set above bit 3 decode as NOP.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4
)(
    input  logic [OPCODE_W-1:0] i_opcode,
    output ctrl_bundle_t        o_ctrl
);

    logic [3:0] w_op;
    logic       w_upperZero;

    assign w_op        = i_opcode[3:0];
    assign w_upperZero = ((i_opcode >> 4) == '0);

    always_comb begin
        o_ctrl          = '0;
        o_ctrl.alu_ctrl = ALU_ADD;
        if (w_upperZero) begin
            if (!w_op[3]) begin
                o_ctrl.alu_ctrl = w_op[2:0];
                o_ctrl.reg_we   = 1'b1;
                o_ctrl.re_a     = 1'b1;
                o_ctrl.re_b     = (w_op != OP_NOT);
            end else begin
                case (w_op)
                    OP_CMP: begin
                        o_ctrl.alu_ctrl = ALU_SUB;
                        o_ctrl.re_a     = 1'b1;
                        o_ctrl.re_b     = 1'b1;
                        o_ctrl.cmp_en   = 1'b1;
                    end
                    OP_MOV: begin
                        o_ctrl.reg_we       = 1'b1;
                        o_ctrl.sel_data_out = SEL_OUT_IMM;
                    end
                    OP_LD: begin
                        o_ctrl.sel_b        = SEL_B_LOAD;
                        o_ctrl.re_a         = 1'b1;
                        o_ctrl.mem_re       = 1'b1;
                        o_ctrl.reg_we       = 1'b1;
                        o_ctrl.sel_data_out = SEL_OUT_LOAD;
                        o_ctrl.is_load      = 1'b1;
                    end
                    OP_ST: begin
                        o_ctrl.sel_b  = SEL_B_STORE;
                        o_ctrl.re_a   = 1'b1;
                        o_ctrl.re_b   = 1'b1;
                        o_ctrl.mem_we = 1'b1;
                    end
                    OP_BT: begin
                        o_ctrl.branch = 1'b1;
                    end
                    OP_NOP: ;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/ctrl_pipeline.sv
// Pipelined control path: ID decode, EX/MEM/WB control registers, RAW stall, compare flag and branch flush.
// Define CTRL_FORWARD_EN to add operand-forwarding selects and reduce stalls to load-use only.
module ctrl_pipeline
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W   = 4,
    parameter int REG_ADDR_W = 4,
    parameter int ALU_CTRL_W = 3
)(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_id_valid,
    output logic                  o_id_ready,
    input  logic [OPCODE_W-1:0]   i_id_opcode,
    input  logic [REG_ADDR_W-1:0] i_id_rs_a,
    input  logic [REG_ADDR_W-1:0] i_id_rs_b,
    input  logic [REG_ADDR_W-1:0] i_id_rd,
    input  logic                  i_ex_cmp_result,
    output logic                  o_ex_valid,
    output logic [1:0]            o_ex_sel_b,
    output logic [ALU_CTRL_W-1:0] o_ex_alu_ctrl,
    output logic                  o_mem_we,
    output logic                  o_mem_re,
    output logic                  o_wb_reg_we,
    output logic [1:0]            o_wb_sel_data_out,
    output logic [REG_ADDR_W-1:0] o_wb_rd,
`ifdef CTRL_FORWARD_EN
    output logic [1:0]            o_ex_fwd_a,
    output logic [1:0]            o_ex_fwd_b,
`endif
    output logic                  o_stall,
    output logic                  o_branch_taken,
    output logic                  o_flush
);

`ifdef CTRL_FORWARD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    ctrl_bundle_t w_idCtrl;

    logic                  r_exValid;
    sel_b_t                r_exSelB;
    logic [2:0]            r_exAluCtrl;
    logic                  r_exMemWe;
    logic                  r_exMemRe;
    logic                  r_exRegWe;
    sel_out_t              r_exSelOut;
    logic                  r_exCmpEn;
    logic                  r_exBranch;
    logic                  r_exIsLoad;
    logic [REG_ADDR_W-1:0] r_exRd;

    logic                  r_memValid;
    logic                  r_memWe;
    logic                  r_memRe;
    logic                  r_memRegWe;
    sel_out_t              r_memSelOut;
    logic [REG_ADDR_W-1:0] r_memRd;

    logic                  r_wbValid;
    logic                  r_wbRegWe;
    sel_out_t              r_wbSelOut;
    logic [REG_ADDR_W-1:0] r_wbRd;

    logic                  r_flag;

    logic w_exProd;
    logic w_memProd;
    logic w_exMatchA;
    logic w_exMatchB;
    logic w_memMatchA;
    logic w_memMatchB;
    logic w_exHit;
    logic w_memHit;
    logic w_hazard;
    logic w_accept;

    ctrl_decode #(
        .OPCODE_W (OPCODE_W)
    ) u_decode (
        .i_opcode (i_id_opcode),
        .o_ctrl   (w_idCtrl)
    );

    // WB is absent here: the register file writes through, so its result is already visible to ID.
    assign w_exProd    = r_exValid & r_exRegWe;
    assign w_memProd   = r_memValid & r_memRegWe;
    assign w_exMatchA  = w_exProd  & w_idCtrl.re_a & (r_exRd  == i_id_rs_a);
    assign w_exMatchB  = w_exProd  & w_idCtrl.re_b & (r_exRd  == i_id_rs_b);
    assign w_memMatchA = w_memProd & w_idCtrl.re_a & (r_memRd == i_id_rs_a);
    assign w_memMatchB = w_memProd & w_idCtrl.re_b & (r_memRd == i_id_rs_b);
    assign w_exHit     = w_exMatchA | w_exMatchB;
    assign w_memHit    = w_memMatchA | w_memMatchB;

    // With forwarding only a load in EX is too late to bypass; everything else is covered by fwd selects.
    assign w_hazard = FWD_EN ? (w_exHit & r_exIsLoad) : (w_exHit | w_memHit);

    assign o_stall        = i_id_valid & w_hazard;
    assign o_branch_taken = r_exValid & r_exBranch & r_flag;
    assign o_flush        = o_branch_taken;
    assign o_id_ready     = ~o_stall | o_flush;
    assign w_accept       = i_id_valid & o_id_ready & ~o_flush;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_exValid   <= 1'b0;
            r_exSelB    <= SEL_B_ALU;
            r_exAluCtrl <= '0;
            r_exMemWe   <= 1'b0;
            r_exMemRe   <= 1'b0;
            r_exRegWe   <= 1'b0;
            r_exSelOut  <= SEL_OUT_ALU;
            r_exCmpEn   <= 1'b0;
            r_exBranch  <= 1'b0;
            r_exIsLoad  <= 1'b0;
            r_exRd      <= '0;
        end else begin
            r_exValid   <= w_accept;
            r_exSelB    <= w_accept ? w_idCtrl.sel_b : SEL_B_ALU;
            r_exAluCtrl <= w_accept ? w_idCtrl.alu_ctrl : 3'b000;
            r_exMemWe   <= w_accept & w_idCtrl.mem_we;
            r_exMemRe   <= w_accept & w_idCtrl.mem_re;
            r_exRegWe   <= w_accept & w_idCtrl.reg_we;
            r_exSelOut  <= w_accept ? w_idCtrl.sel_data_out : SEL_OUT_ALU;
            r_exCmpEn   <= w_accept & w_idCtrl.cmp_en;
            r_exBranch  <= w_accept & w_idCtrl.branch;
            r_exIsLoad  <= w_accept & w_idCtrl.is_load;
            r_exRd      <= w_accept ? i_id_rd : '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_memValid  <= 1'b0;
            r_memWe     <= 1'b0;
            r_memRe     <= 1'b0;
            r_memRegWe  <= 1'b0;
            r_memSelOut <= SEL_OUT_ALU;
            r_memRd     <= '0;
            r_wbValid   <= 1'b0;
            r_wbRegWe   <= 1'b0;
            r_wbSelOut  <= SEL_OUT_ALU;
            r_wbRd      <= '0;
        end else begin
            r_memValid  <= r_exValid;
            r_memWe     <= r_exMemWe;
            r_memRe     <= r_exMemRe;
            r_memRegWe  <= r_exRegWe;
            r_memSelOut <= r_exSelOut;
            r_memRd     <= r_exRd;
            r_wbValid   <= r_memValid;
            r_wbRegWe   <= r_memRegWe;
            r_wbSelOut  <= r_memSelOut;
            r_wbRd      <= r_memRd;
        end
    end

    // The flag is written at the end of CMP's EX cycle, so a BT directly behind it sees the fresh value.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_flag <= 1'b0;
        else if (r_exValid & r_exCmpEn)
            r_flag <= i_ex_cmp_result;
    end

`ifdef CTRL_FORWARD_EN
    logic [1:0] r_exFwdA;
    logic [1:0] r_exFwdB;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_exFwdA <= FWD_REGFILE;
            r_exFwdB <= FWD_REGFILE;
        end else begin
            r_exFwdA <= w_accept ? fwdSelect(w_exMatchA, w_memMatchA) : FWD_REGFILE;
            r_exFwdB <= w_accept ? fwdSelect(w_exMatchB, w_memMatchB) : FWD_REGFILE;
        end
    end

    assign o_ex_fwd_a = r_exValid ? r_exFwdA : FWD_REGFILE;
    assign o_ex_fwd_b = r_exValid ? r_exFwdB : FWD_REGFILE;
`endif

    assign o_ex_valid        = r_exValid;
    assign o_ex_sel_b        = r_exValid ? r_exSelB : SEL_B_ALU;
    assign o_ex_alu_ctrl     = r_exValid ? ALU_CTRL_W'(r_exAluCtrl) : '0;
    assign o_mem_we          = r_memValid & r_memWe;
    assign o_mem_re          = r_memValid & r_memRe;
    assign o_wb_reg_we       = r_wbValid & r_wbRegWe;
    assign o_wb_sel_data_out = r_wbValid ? r_wbSelOut : SEL_OUT_ALU;
    assign o_wb_rd           = r_wbValid ? r_wbRd : '0;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Self-checking bench for ctrl_pipeline: directed scenarios then random traffic, all checked against an
// instruction-level model. Builds with or without CTRL_FORWARD_EN; a 5-bit opcode exercises the NOP-on-upper-bits rule.
module tb_ctrl_pipeline;
    import ctrl_pkg::*;

    localparam int OPW = 5;

    typedef struct {
        bit         valid;
        logic [3:0] op;
        logic [3:0] rsa;
        logic [3:0] rsb;
        logic [3:0] rd;
        logic [1:0] fwdA;
        logic [1:0] fwdB;
    } slot_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           idValid = 1'b0;
    logic [OPW-1:0] idOpcode = '0;
    logic [3:0]     rsA = '0;
    logic [3:0]     rsB = '0;
    logic [3:0]     rd = '0;
    logic           cmpResult = 1'b0;

    logic       idReady;
    logic       exValid;
    logic [1:0] exSelB;
    logic [2:0] exAluCtrl;
    logic       memWe;
    logic       memRe;
    logic       wbRegWe;
    logic [1:0] wbSelOut;
    logic [3:0] wbRd;
    logic       stall;
    logic       branchTaken;
    logic       flush;
`ifdef CTRL_FORWARD_EN
    logic [1:0] exFwdA;
    logic [1:0] exFwdB;
`endif

    int assertCount = 0;
    int failCount = 0;

    slot_t mEx, mMem, mWb;
    bit    mFlag = 1'b0;
    bit    modelKnown = 1'b0;
    bit    eStall, eFlush, eReady, eAccept, eConsumed;
    logic [1:0] eFwdA, eFwdB;

    ctrl_pipeline #(
        .OPCODE_W   (OPW),
        .REG_ADDR_W (4),
        .ALU_CTRL_W (3)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_id_valid        (idValid),
        .o_id_ready        (idReady),
        .i_id_opcode       (idOpcode),
        .i_id_rs_a         (rsA),
        .i_id_rs_b         (rsB),
        .i_id_rd           (rd),
        .i_ex_cmp_result   (cmpResult),
        .o_ex_valid        (exValid),
        .o_ex_sel_b        (exSelB),
        .o_ex_alu_ctrl     (exAluCtrl),
        .o_mem_we          (memWe),
        .o_mem_re          (memRe),
        .o_wb_reg_we       (wbRegWe),
        .o_wb_sel_data_out (wbSelOut),
        .o_wb_rd           (wbRd),
`ifdef CTRL_FORWARD_EN
        .o_ex_fwd_a        (exFwdA),
        .o_ex_fwd_b        (exFwdB),
`endif
        .o_stall           (stall),
        .o_branch_taken    (branchTaken),
        .o_flush           (flush)
    );

    always #5 clk = ~clk;

    // Instruction semantics from the opcode table
    function automatic logic [3:0] effOp(input logic [OPW-1:0] op);
        logic [3:0] low;
        low = op[3:0];
        return ((op >> 4) != 0) ? OP_NOP : low;
    endfunction

    function automatic bit writesReg(input logic [3:0] op);
        return (op < 4'd8) || (op == OP_MOV) || (op == OP_LD);
    endfunction

    function automatic bit readsA(input logic [3:0] op);
        return (op < 4'd8) || (op == OP_CMP) || (op == OP_LD) || (op == OP_ST);
    endfunction

    function automatic bit readsB(input logic [3:0] op);
        return ((op < 4'd8) && (op != OP_NOT)) || (op == OP_CMP) || (op == OP_ST);
    endfunction

    function automatic logic [2:0] aluOf(input logic [3:0] op);
        if (op < 4'd8) return op[2:0];
        if (op == OP_CMP) return ALU_SUB;
        return ALU_ADD;
    endfunction

    function automatic logic [1:0] selBOf(input logic [3:0] op);
        if (op == OP_LD) return 2'd1;
        if (op == OP_ST) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [1:0] wbSelOf(input logic [3:0] op);
        if (op == OP_MOV) return 2'd1;
        if (op == OP_LD) return 2'd2;
        return 2'd0;
    endfunction

    function automatic bit produces(input slot_t p, input logic [3:0] r);
        return p.valid && writesReg(p.op) && (p.rd == r);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic computeExpected();
        logic [3:0] op;
        bit depEx, depMem, aEx, aMem, bEx, bMem;
        op     = effOp(idOpcode);
        aEx    = readsA(op) && produces(mEx, rsA);
        bEx    = readsB(op) && produces(mEx, rsB);
        aMem   = readsA(op) && produces(mMem, rsA);
        bMem   = readsB(op) && produces(mMem, rsB);
        depEx  = aEx || bEx;
        depMem = aMem || bMem;
`ifdef CTRL_FORWARD_EN
        eStall = idValid && depEx && (mEx.op == OP_LD);
`else
        eStall = idValid && (depEx || depMem);
`endif
        eFlush    = mEx.valid && (mEx.op == OP_BT) && mFlag;
        eReady    = !eStall || eFlush;
        eAccept   = idValid && eReady && !eFlush;
        eConsumed = idValid && eReady;
        eFwdA     = aEx ? 2'b01 : (aMem ? 2'b10 : 2'b00);
        eFwdB     = bEx ? 2'b01 : (bMem ? 2'b10 : 2'b00);
    endtask

    task automatic compareAll();
        checkOutput("ex_valid",     exValid,     mEx.valid);
        checkOutput("ex_sel_b",     exSelB,      mEx.valid ? selBOf(mEx.op) : 2'd0);
        checkOutput("ex_alu_ctrl",  exAluCtrl,   mEx.valid ? aluOf(mEx.op) : 3'd0);
        checkOutput("mem_we",       memWe,       mMem.valid && (mMem.op == OP_ST));
        checkOutput("mem_re",       memRe,       mMem.valid && (mMem.op == OP_LD));
        checkOutput("wb_reg_we",    wbRegWe,     mWb.valid && writesReg(mWb.op));
        checkOutput("wb_sel",       wbSelOut,    mWb.valid ? wbSelOf(mWb.op) : 2'd0);
        checkOutput("wb_rd",        wbRd,        mWb.valid ? mWb.rd : 4'd0);
        checkOutput("stall",        stall,       eStall);
        checkOutput("branch_taken", branchTaken, eFlush);
        checkOutput("flush",        flush,       eFlush);
        checkOutput("id_ready",     idReady,     eReady);
`ifdef CTRL_FORWARD_EN
        checkOutput("ex_fwd_a",     exFwdA,      mEx.valid ? mEx.fwdA : 2'd0);
        checkOutput("ex_fwd_b",     exFwdB,      mEx.valid ? mEx.fwdB : 2'd0);
`endif
    endtask

    task automatic stepModel();
        if (rst) begin
            mEx.valid  = 1'b0;
            mMem.valid = 1'b0;
            mWb.valid  = 1'b0;
            mFlag      = 1'b0;
            modelKnown = 1'b1;
        end else begin
            if (mEx.valid && (mEx.op == OP_CMP))
                mFlag = cmpResult;
            mWb       = mMem;
            mMem      = mEx;
            mEx.valid = eAccept;
            mEx.op    = effOp(idOpcode);
            mEx.rsa   = rsA;
            mEx.rsb   = rsB;
            mEx.rd    = rd;
            mEx.fwdA  = eFwdA;
            mEx.fwdB  = eFwdB;
        end
    endtask

    task automatic applyStimulus(input bit r, input bit v, input logic [OPW-1:0] op,
                                 input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                                 input bit c);
        @(negedge clk);
        rst       = r;
        idValid   = v;
        idOpcode  = op;
        rsA       = a;
        rsB       = b;
        rd        = d;
        cmpResult = c;
        #1;
        computeExpected();
        if (modelKnown)
            compareAll();
        @(posedge clk);
        stepModel();
    endtask

    // Holds one instruction in ID until the DUT consumes it, giving up after a few cycles
    task automatic issue(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] d, input bit c);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 4 && !done; k++) begin
            applyStimulus(1'b0, 1'b1, {1'b0, op}, a, b, d, c);
            done = idReady;
        end
        checkOutput("issue_consumed", done, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
    endtask

    initial begin
        logic [OPW-1:0] rOp;
        logic [3:0]     rA, rB, rD;
        bit             rV, rR;

        mEx.valid  = 1'b0;
        mMem.valid = 1'b0;
        mWb.valid  = 1'b0;

        applyStimulus(1'b1, 1'b0, '0, '0, '0, '0, 1'b0);
        applyStimulus(1'b1, 1'b0, '0, '0, '0, '0, 1'b0);

        $display("[TB] single ADD through the pipe");
        issue(4'b0001, 4'd0, 4'd0, 4'd3, 1'b0);
        idle(4);

        $display("[TB] ADD then dependent SUB");
        issue(4'b0001, 4'd0, 4'd0, 4'd2, 1'b0);
        issue(4'b0010, 4'd2, 4'd0, 4'd4, 1'b0);
        idle(4);

        $display("[TB] load-use");
        issue(OP_LD,   4'd1, 4'd0, 4'd5, 1'b0);
        issue(4'b0001, 4'd0, 4'd5, 4'd6, 1'b0);
        idle(4);

        $display("[TB] taken branch");
        issue(OP_CMP,  4'd0, 4'd0, 4'd0, 1'b0);
        issue(OP_BT,   4'd0, 4'd0, 4'd0, 1'b1);
        issue(4'b0001, 4'd0, 4'd0, 4'd7, 1'b0);
        idle(4);

        $display("[TB] not-taken branch");
        issue(OP_CMP,  4'd0, 4'd0, 4'd0, 1'b0);
        issue(OP_BT,   4'd0, 4'd0, 4'd0, 1'b0);
        issue(4'b0001, 4'd0, 4'd0, 4'd6, 1'b0);
        idle(4);

        $display("[TB] reset during stall");
        issue(4'b0001, 4'd0, 4'd0, 4'd1, 1'b0);
        issue(4'b0001, 4'd0, 4'd0, 4'd4, 1'b0);
        issue(OP_LD,   4'd0, 4'd0, 4'd2, 1'b0);
        applyStimulus(1'b0, 1'b1, {1'b0, 4'b0010}, 4'd2, 4'd0, 4'd3, 1'b0);
        applyStimulus(1'b1, 1'b1, {1'b0, 4'b0010}, 4'd2, 4'd0, 4'd3, 1'b0);
        idle(3);

        $display("[TB] random traffic");
        rV = 1'b1; rOp = '0; rA = '0; rB = '0; rD = '0;
        for (int n = 0; n < 800; n++) begin
            rR = ($urandom_range(0, 63) == 0);
            applyStimulus(rR, rV, rOp, rA, rB, rD, 1'($urandom_range(0, 1)));
            if (rR || !rV || eConsumed) begin
                rV = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 3) == 0)
                    rOp = ($urandom_range(0, 1) != 0) ? OPW'(OP_CMP) : OPW'(OP_BT);
                else
                    rOp = OPW'($urandom_range(0, 15));
                if ($urandom_range(0, 7) == 0)
                    rOp[4] = 1'b1;
                rA = 4'($urandom_range(0, 3));
                rB = 4'($urandom_range(0, 3));
                rD = 4'($urandom_range(0, 3));
            end
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
